// File: rtl/hash_occurrence_counter_pkg.sv
// Shared widths, FSM state encoding and width helper for the hash occurrence counter.
package hash_occurrence_counter_pkg;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int LENGTH_ARRAY     = 100;
    localparam int DATA_INDEX_WIDTH = 32;
    localparam int BIT_ON_TAILS     = 7;

    localparam int HD   = 1 << BIT_ON_TAILS;
    localparam int LAW  = log2(LENGTH_ARRAY);
    localparam int HAW  = log2(1 << (BIT_ON_TAILS + 1));
    localparam int CW   = log2(LENGTH_ARRAY + 1);
    localparam int MASK = HD - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COUNT,
        ST_DONE
    } hoc_state_t;

endpackage

// File: rtl/hash_rmw_pipe.sv
// Histogram table with a 3-stage read-modify-write increment pipe, clear port,
// registered read port and running maximum tracker.
import hash_occurrence_counter_pkg::*;

module hash_rmw_pipe (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    iss_valid,
    input  logic [BIT_ON_TAILS-1:0] iss_idx,
    input  logic                    clr_we,
    input  logic [BIT_ON_TAILS-1:0] clr_idx,
    input  logic                    rd_req,
    input  logic [BIT_ON_TAILS-1:0] rd_idx,
    output logic                    rd_valid,
    output logic [CW-1:0]           rd_count,
    output logic [BIT_ON_TAILS-1:0] max_bucket,
    output logic [CW-1:0]           max_count,
    output logic                    busy
);

    localparam logic [CW-1:0] SAT = CW'(LENGTH_ARRAY);

    logic [CW-1:0]           table_mem [HD];
    logic                    s1_valid;
    logic                    s2_valid;
    logic [BIT_ON_TAILS-1:0] s1_idx;
    logic [BIT_ON_TAILS-1:0] s2_idx;
    logic [CW-1:0]           s2_count;
    logic [CW-1:0]           s1_old;

    // Back-to-back hits on one bucket take the value still in flight in S2.
    assign s1_old = (s2_valid && (s2_idx == s1_idx)) ? s2_count : table_mem[s1_idx];
    assign busy   = s1_valid | s2_valid;

    always_ff @(posedge clk) begin
        if (clr_we)
            table_mem[clr_idx] <= '0;
        else if (s2_valid)
            table_mem[s2_idx] <= s2_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_idx     <= '0;
            s2_idx     <= '0;
            s2_count   <= '0;
            max_count  <= '0;
            max_bucket <= '0;
            rd_valid   <= 1'b0;
            rd_count   <= '0;
        end else begin
            s1_valid <= iss_valid && !flush;
            s1_idx   <= iss_idx;
            s2_valid <= s1_valid && !flush;
            s2_idx   <= s1_idx;
            s2_count <= (s1_old == SAT) ? s1_old : s1_old + 1'b1;
            if (flush) begin
                max_count  <= '0;
                max_bucket <= '0;
            end else if (s2_valid && (s2_count > max_count)) begin
                max_count  <= s2_count;
                max_bucket <= s2_idx;
            end
            rd_valid <= rd_req;
            if (rd_req)
                rd_count <= table_mem[rd_idx];
        end
    end

endmodule

// File: rtl/hash_occurrence_counter.sv
// Sample buffer and round sequencer for the hash occurrence histogram.
// state    | meaning
// ST_IDLE  | waiting for the first clear strobe; samples are buffered
// ST_CLEAR | zeroing table entries, samples still buffered
// ST_COUNT | replaying buffered tails through the RMW pipe
// ST_DONE  | histogram final, read port live
import hash_occurrence_counter_pkg::*;

module hash_occurrence_counter (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        WrInitStreamData,
    input  logic [LAW-1:0]              AddrInitStreamData,
    input  logic [DATA_INDEX_WIDTH-1:0] InitStreamData,
    input  logic                        WrInitHash,
    input  logic [HAW-1:0]              AddrInitHashOccurr,
    input  logic                        rd_en,
    input  logic [BIT_ON_TAILS-1:0]     rd_addr,
    output logic [CW-1:0]               rd_count,
    output logic                        rd_valid,
    output logic                        CountDone,
    output logic [BIT_ON_TAILS-1:0]     MaxBucket,
    output logic [CW-1:0]               MaxCount,
    output logic                        Overflow
);

    localparam logic [CW-1:0]               LEN_P  = CW'(LENGTH_ARRAY);
    localparam logic [HAW-1:0]              HD_P   = HAW'(HD);
    localparam logic [DATA_INDEX_WIDTH-1:0] MASK_P = DATA_INDEX_WIDTH'(MASK);

    hoc_state_t                  state;
    logic [CW-1:0]               wr_ptr;
    logic [CW-1:0]               rd_ptr;
    logic [HAW-1:0]              clr_cnt;
    logic [BIT_ON_TAILS-1:0]     buf_mem [LENGTH_ARRAY];
    logic [DATA_INDEX_WIDTH-1:0] masked;
    logic [BIT_ON_TAILS-1:0]     tail;
    logic                        enter_clr;
    logic                        clr_done;
    logic                        smp_we;
    logic                        smp_drop;
    logic [CW-1:0]               smp_addr;
    logic                        iss_valid;
    logic                        pipe_busy;
    logic                        unused_inputs;

    assign masked        = InitStreamData & MASK_P;
    assign tail          = masked[BIT_ON_TAILS-1:0];
    assign unused_inputs = ^{AddrInitStreamData, AddrInitHashOccurr[HAW-1:BIT_ON_TAILS],
                             masked[DATA_INDEX_WIDTH-1:BIT_ON_TAILS]};

    assign clr_done  = (state == ST_CLEAR) && (clr_cnt == HD_P);
    assign enter_clr = WrInitHash && (state != ST_CLEAR);
    assign iss_valid = (state == ST_COUNT) && !WrInitHash && (rd_ptr < wr_ptr);

    // A sample coinciding with an abort belongs to the new round, so it lands in slot 0.
    always_comb begin
        smp_we   = 1'b0;
        smp_drop = 1'b0;
        smp_addr = wr_ptr;
        if (WrInitStreamData && (state != ST_DONE)) begin
            if (enter_clr && (state == ST_COUNT)) begin
                smp_we   = 1'b1;
                smp_addr = '0;
            end else if (wr_ptr < LEN_P) begin
                smp_we = 1'b1;
            end else begin
                smp_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (smp_we)
            buf_mem[smp_addr] <= tail;
    end

    // The strobe that opens CLEAR also zeroes its entry, so it counts as the first clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            clr_cnt   <= '0;
            Overflow  <= 1'b0;
            CountDone <= 1'b0;
        end else begin
            if (smp_we)
                wr_ptr <= smp_addr + 1'b1;
            if (iss_valid)
                rd_ptr <= rd_ptr + 1'b1;
            if (smp_drop)
                Overflow <= 1'b1;
            if (enter_clr) begin
                state     <= ST_CLEAR;
                clr_cnt   <= HAW'(1);
                rd_ptr    <= '0;
                Overflow  <= smp_drop;
                CountDone <= 1'b0;
                if ((state != ST_IDLE) && !smp_we)
                    wr_ptr <= '0;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        if (clr_done)
                            state <= ST_COUNT;
                        else if (WrInitHash)
                            clr_cnt <= clr_cnt + 1'b1;
                    end
                    ST_COUNT: begin
                        if ((rd_ptr == LEN_P) && !pipe_busy) begin
                            state     <= ST_DONE;
                            CountDone <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    hash_rmw_pipe u_pipe (
        .clk        (clk),
        .rst        (rst),
        .flush      (enter_clr),
        .iss_valid  (iss_valid),
        .iss_idx    (buf_mem[rd_ptr]),
        .clr_we     (WrInitHash && !clr_done),
        .clr_idx    (AddrInitHashOccurr[BIT_ON_TAILS-1:0]),
        .rd_req     (rd_en && (state == ST_DONE)),
        .rd_idx     (rd_addr),
        .rd_valid   (rd_valid),
        .rd_count   (rd_count),
        .max_bucket (MaxBucket),
        .max_count  (MaxCount),
        .busy       (pipe_busy)
    );

endmodule
